// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: steps each instruction through fetch, decode, execute,
// memory and writeback around memory handshakes, with illegal-opcode and wait-timeout traps.
module multicycle_control #(
    parameter int MAX_WAIT        = 255,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       alusrc,
    output logic       memread,
    output logic       memwrite,
    output logic       branch,
    output logic       lui,
    output logic       auipc,
    output logic       jal,
    output logic       jalr,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       branch;
        logic [1:0] aluop;
        logic       lui;
        logic       auipc;
        logic       jal;
        logic       jalr;
        logic       is_load;
        logic       is_store;
    } dec_t;

    state_t        state_q, state_d;
    dec_t          dec_q, dec_d, dec_new;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    logic          opc_legal;
    logic          wait_hit;
    logic          lat_en;

    always_comb begin
        dec_new   = '0;
        opc_legal = 1'b1;
        case (opcode)
            7'b0110011: dec_new.aluop = 2'b10;
            7'b0000011: begin
                dec_new.alusrc   = 1'b1;
                dec_new.memtoreg = 1'b1;
                dec_new.is_load  = 1'b1;
            end
            7'b0100011: begin
                dec_new.alusrc   = 1'b1;
                dec_new.is_store = 1'b1;
            end
            7'b1100011: begin
                dec_new.branch = 1'b1;
                dec_new.aluop  = 2'b01;
            end
            7'b0010011: begin
                dec_new.alusrc = 1'b1;
                dec_new.aluop  = 2'b11;
            end
            7'b0110111: begin
                dec_new.alusrc = 1'b1;
                dec_new.lui    = 1'b1;
            end
            7'b0010111: begin
                dec_new.alusrc = 1'b1;
                dec_new.auipc  = 1'b1;
            end
            7'b1101111: begin
                dec_new.alusrc = 1'b1;
                dec_new.jal    = 1'b1;
            end
            7'b1100111: begin
                dec_new.alusrc = 1'b1;
                dec_new.jalr   = 1'b1;
            end
            default: opc_legal = 1'b0;
        endcase
    end

    // The current not-ready cycle is the MAX_WAIT-th in a row: a ready this cycle still wins.
    assign wait_hit = (MAX_WAIT > 0) && (int'(wait_q) == MAX_WAIT - 1);

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_DECODE: begin
                dec_d = dec_new;
                if (opc_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end
            end
            S_EXEC: begin
                if (dec_q.is_load || dec_q.is_store) state_d = S_MEM;
                else if (dec_q.branch)               state_d = S_FETCH;
                else                                 state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = dec_q.is_load ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dec_q     <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes derive from the registered state so an async reset drops them at once.
    assign lat_en = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_DECODE: pc_write = !opc_legal && !TRAP_ON_ILLEGAL;
            S_EXEC:   pc_write = dec_q.branch;
            S_MEM: begin
                dmem_req = 1'b1;
                memread  = dec_q.is_load;
                memwrite = dec_q.is_store;
                pc_write = dec_q.is_store && dmem_ready;
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign memtoreg = lat_en && dec_q.memtoreg;
    assign alusrc   = lat_en && dec_q.alusrc;
    assign branch   = lat_en && dec_q.branch;
    assign aluop    = lat_en ? dec_q.aluop : 2'b00;
    assign lui      = lat_en && dec_q.lui;
    assign auipc    = lat_en && dec_q.auipc;
    assign jal      = lat_en && dec_q.jal;
    assign jalr     = lat_en && dec_q.jalr;
    assign illegal  = illegal_q;
    assign timeout  = timeout_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two parameterisations share stimulus and are each compared
// cycle by cycle against a phase-plan model of the instruction sequencing rules.
module tb_multicycle_control;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam int C_ILL = -1, C_NONE = 0, C_R = 1, C_LW = 2, C_SW = 3, C_B = 4, C_I = 5;
    localparam int C_LUI = 6, C_AUIPC = 7, C_JAL = 8, C_JALR = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;

    logic       a_imem_req, a_dmem_req, a_ir_write, a_pc_write, a_regwrite, a_memtoreg, a_alusrc;
    logic       a_memread, a_memwrite, a_branch, a_lui, a_auipc, a_jal, a_jalr, a_illegal, a_timeout;
    logic [1:0] a_aluop;
    logic [2:0] a_state;
    logic       b_imem_req, b_dmem_req, b_ir_write, b_pc_write, b_regwrite, b_memtoreg, b_alusrc;
    logic       b_memread, b_memwrite, b_branch, b_lui, b_auipc, b_jal, b_jalr, b_illegal, b_timeout;
    logic [1:0] b_aluop;
    logic [2:0] b_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MAX_WAIT(4), .TRAP_ON_ILLEGAL(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(a_imem_req), .dmem_req(a_dmem_req), .ir_write(a_ir_write), .pc_write(a_pc_write),
        .regwrite(a_regwrite), .memtoreg(a_memtoreg), .alusrc(a_alusrc), .memread(a_memread),
        .memwrite(a_memwrite), .branch(a_branch), .lui(a_lui), .auipc(a_auipc), .jal(a_jal),
        .jalr(a_jalr), .aluop(a_aluop), .illegal(a_illegal), .timeout(a_timeout), .state(a_state)
    );

    multicycle_control #(.MAX_WAIT(0), .TRAP_ON_ILLEGAL(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(b_imem_req), .dmem_req(b_dmem_req), .ir_write(b_ir_write), .pc_write(b_pc_write),
        .regwrite(b_regwrite), .memtoreg(b_memtoreg), .alusrc(b_alusrc), .memread(b_memread),
        .memwrite(b_memwrite), .branch(b_branch), .lui(b_lui), .auipc(b_auipc), .jal(b_jal),
        .jalr(b_jalr), .aluop(b_aluop), .illegal(b_illegal), .timeout(b_timeout), .state(b_state)
    );

    logic [20:0] out_vec [2];
    assign out_vec[0] = {a_imem_req, a_dmem_req, a_ir_write, a_pc_write, a_regwrite, a_memtoreg,
                         a_alusrc, a_memread, a_memwrite, a_branch, a_lui, a_auipc, a_jal, a_jalr,
                         a_aluop, a_illegal, a_timeout, a_state};
    assign out_vec[1] = {b_imem_req, b_dmem_req, b_ir_write, b_pc_write, b_regwrite, b_memtoreg,
                         b_alusrc, b_memread, b_memwrite, b_branch, b_lui, b_auipc, b_jal, b_jalr,
                         b_aluop, b_illegal, b_timeout, b_state};

    // Model: phase number (spec state encoding), decoded class and a plan of phases left to run.
    int m_ph    [2];
    int m_cls   [2];
    int m_waits [2];
    bit m_ill   [2];
    bit m_tmo   [2];
    int m_plan  [2][3];
    int m_plen  [2];
    int m_pidx  [2];
    int m_maxw  [2] = '{4, 0};
    bit m_trap  [2] = '{1'b1, 1'b0};

    function automatic int classify(logic [6:0] op);
        case (op)
            OP_R:     return C_R;
            OP_LW:    return C_LW;
            OP_SW:    return C_SW;
            OP_B:     return C_B;
            OP_I:     return C_I;
            OP_LUI:   return C_LUI;
            OP_AUIPC: return C_AUIPC;
            OP_JAL:   return C_JAL;
            OP_JALR:  return C_JALR;
            default:  return C_ILL;
        endcase
    endfunction

    task automatic model_reset(int i);
        m_ph[i] = 0; m_cls[i] = C_NONE; m_waits[i] = 0;
        m_ill[i] = 1'b0; m_tmo[i] = 1'b0; m_plen[i] = 0; m_pidx[i] = 0;
    endtask

    task automatic model_advance(int i);
        if (m_pidx[i] < m_plen[i]) begin
            m_ph[i] = m_plan[i][m_pidx[i]];
            m_pidx[i]++;
        end else begin
            m_ph[i] = 1;
        end
    endtask

    task automatic model_step(int i, logic [6:0] op, logic ir, logic dr);
        int  c;
        logic rdy;
        case (m_ph[i])
            0: m_ph[i] = 1;
            1, 4: begin
                rdy = (m_ph[i] == 1) ? ir : dr;
                if (rdy) begin
                    m_waits[i] = 0;
                    if (m_ph[i] == 1) m_ph[i] = 2;
                    else              model_advance(i);
                end else begin
                    m_waits[i]++;
                    if (m_maxw[i] > 0 && m_waits[i] >= m_maxw[i]) begin
                        m_ph[i] = 6;
                        m_tmo[i] = 1'b1;
                    end
                end
            end
            2: begin
                c = classify(op);
                if (c == C_ILL) begin
                    m_ill[i] = 1'b1;
                    m_ph[i]  = m_trap[i] ? 6 : 1;
                end else begin
                    m_cls[i]  = c;
                    m_pidx[i] = 0;
                    case (c)
                        C_LW:    begin m_plan[i] = '{3, 4, 5}; m_plen[i] = 3; end
                        C_SW:    begin m_plan[i] = '{3, 4, 0}; m_plen[i] = 2; end
                        C_B:     begin m_plan[i] = '{3, 0, 0}; m_plen[i] = 1; end
                        default: begin m_plan[i] = '{3, 5, 0}; m_plen[i] = 2; end
                    endcase
                    model_advance(i);
                end
            end
            3, 5: model_advance(i);
            default: ;
        endcase
    endtask

    function automatic logic [20:0] expect_vec(int i, logic [6:0] op, logic ir, logic dr);
        int   ph = m_ph[i];
        int   c  = (ph >= 3 && ph <= 5) ? m_cls[i] : C_NONE;
        logic [1:0] aop;
        logic pcw, asrc;
        aop  = (c == C_R) ? 2'b10 : (c == C_B) ? 2'b01 : (c == C_I) ? 2'b11 : 2'b00;
        asrc = c inside {C_LW, C_SW, C_I, C_LUI, C_AUIPC, C_JAL, C_JALR};
        pcw  = (ph == 5) || (ph == 3 && c == C_B) || (ph == 4 && c == C_SW && dr) ||
               (ph == 2 && classify(op) == C_ILL && !m_trap[i]);
        return {ph == 1, ph == 4, ph == 1 && ir, pcw, ph == 5, c == C_LW, asrc,
                ph == 4 && c == C_LW, ph == 4 && c == C_SW, c == C_B, c == C_LUI,
                c == C_AUIPC, c == C_JAL, c == C_JALR, aop, m_ill[i], m_tmo[i], 3'(ph)};
    endfunction

    task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Called at a falling edge: drive, check just after, let the rising edge advance the model.
    task automatic applyStimulus(logic [6:0] op, logic ir, logic dr);
        opcode = op; imem_ready = ir; dmem_ready = dr;
        #1;
        checkOutput("dutA_cycle", 32'(out_vec[0]), 32'(expect_vec(0, op, ir, dr)));
        checkOutput("dutB_cycle", 32'(out_vec[1]), 32'(expect_vec(1, op, ir, dr)));
        @(posedge clk);
        model_step(0, op, ir, dr);
        model_step(1, op, ir, dr);
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks that everything drops before any edge, then releases.
    task automatic applyReset();
        #1;
        checkOutput("dutA_pre_reset", 32'(out_vec[0]), 32'(expect_vec(0, opcode, imem_ready, dmem_ready)));
        checkOutput("dutB_pre_reset", 32'(out_vec[1]), 32'(expect_vec(1, opcode, imem_ready, dmem_ready)));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("dutA_async_reset", 32'(out_vec[0]), 32'd0);
        checkOutput("dutB_async_reset", 32'(out_vec[1]), 32'd0);
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [6:0] op_tab [9] = '{OP_R, OP_LW, OP_SW, OP_B, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

    initial begin
        int         stall;
        logic [6:0] rop;
        logic       rir, rdr;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        applyReset();

        $display("[TB] R-type back to back");
        repeat (9) applyStimulus(OP_R, 1'b1, 1'b1);
        $display("[TB] LW with three data wait cycles");
        repeat (3) applyStimulus(OP_LW, 1'b1, 1'b0);
        repeat (3) applyStimulus(OP_LW, 1'b1, 1'b0);
        repeat (2) applyStimulus(OP_LW, 1'b1, 1'b1);
        $display("[TB] SW then B");
        repeat (4) applyStimulus(OP_SW, 1'b1, 1'b1);
        repeat (3) applyStimulus(OP_B, 1'b1, 1'b1);
        $display("[TB] illegal opcode");
        repeat (22) applyStimulus(OP_BAD, 1'b1, 1'b1);

        $display("[TB] fetch timeout");
        applyReset();
        applyStimulus(OP_R, 1'b1, 1'b1);
        repeat (6) applyStimulus(OP_R, 1'b0, 1'b0);
        repeat (3) applyStimulus(OP_R, 1'b1, 1'b1);

        $display("[TB] ready on the last allowed wait cycle");
        applyReset();
        applyStimulus(OP_R, 1'b1, 1'b1);
        repeat (3) applyStimulus(OP_R, 1'b0, 1'b0);
        repeat (4) applyStimulus(OP_R, 1'b1, 1'b1);

        $display("[TB] reset during MEM");
        applyReset();
        repeat (4) applyStimulus(OP_LW, 1'b1, 1'b0);
        dmem_ready = 1'b0;
        applyReset();
        repeat (3) applyStimulus(OP_R, 1'b1, 1'b1);

        $display("[TB] randomized episodes");
        stall = 0;
        for (int ep = 0; ep < 25; ep++) begin
            applyReset();
            for (int n = 0; n < 60; n++) begin
                if (stall == 0 && $urandom_range(0, 15) == 0) stall = $urandom_range(3, 6);
                if ($urandom_range(0, 19) == 0) rop = 7'($urandom);
                else rop = op_tab[$urandom_range(0, 8)];
                rir = (stall == 0) && ($urandom_range(0, 3) != 0);
                rdr = (stall == 0) && ($urandom_range(0, 3) != 0);
                if (stall > 0) stall--;
                applyStimulus(rop, rir, rdr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
